// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU result stage. Holds the
//               op-select codes, the default datapath width, the stored
//               status-flag bundle and the occupancy-state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default datapath width of an ALU result
    localparam int ALU_WIDTH = 32;

    // Op-select codes driven by the upstream operation mux
    localparam int SEL_ADD = 0;
    localparam int SEL_SUB = 1;
    localparam int SEL_XOR = 2;
    localparam int SEL_SLT = 3;
    localparam int SEL_AND = 4;

    // Highest legal select code; anything above is flagged illegal
    localparam int SEL_MAX = SEL_AND;

    // Status flags stored alongside each buffered result
    typedef struct packed {
        logic illegal;
        logic parity;
        logic neg;
        logic zero;
    } flags_t;

    // Occupancy encoding: bit 0 = main register valid, bit 1 = skid valid.
    // Choosing these codes lets out_valid and in_ready come straight
    // from state flop bits with no decode logic.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } occ_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_flag_gen.sv
`default_nettype none
// ============================================================================
// Module      : alu_flag_gen
// Description : Combinational status-flag generator for an ALU result.
//               Ports:
//                 result_i  - result word being captured
//                 sel_i     - op-select code that produced it
//                 flags_o   - zero / neg / parity(odd) / illegal-select
// Revision    : 1.0 - initial release
// ============================================================================
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SEL_W = 3
) (
    input  logic [WIDTH-1:0] result_i,
    input  logic [SEL_W-1:0] sel_i,
    output flags_t           flags_o
);

    localparam logic [SEL_W-1:0] c_sel_max = SEL_W'(SEL_MAX);

    always_comb begin
        flags_o         = '0;
        flags_o.zero    = (result_i == '0);
        flags_o.neg     = result_i[WIDTH-1];
        flags_o.parity  = ^result_i;          // 1 = odd number of ones
        flags_o.illegal = (sel_i > c_sel_max);
    end

endmodule : alu_flag_gen
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Registered output stage behind the ALU op-select mux.
//               Captures result + select code through a valid/ready
//               handshake with a 2-entry (main + skid) buffer, attaches
//               status flags and counts delivered results (saturating).
//               Ports:
//                 clk, reset           - clock, async active-high reset
//                 in_valid/in_ready    - upstream handshake
//                 in_result, in_sel    - result word and its select code
//                 out_valid/out_ready  - downstream handshake
//                 out_result, out_sel  - registered result and select code
//                 out_zero/neg/parity/illegal - registered status flags
//                 result_count         - saturating count of out transfers
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SEL_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [SEL_W-1:0] in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_parity,
    output logic             out_illegal,
    output logic [CNT_W-1:0] result_count
);

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    occ_t             state_q, state_d;

    logic [WIDTH-1:0] main_result_q;
    logic [SEL_W-1:0] main_sel_q;
    flags_t           main_flags_q;

    logic [WIDTH-1:0] skid_result_q;
    logic [SEL_W-1:0] skid_sel_q;
    flags_t           skid_flags_q;

    logic [CNT_W-1:0] count_q;

    // Control strobes from the next-state logic
    logic             w_load_main_in;
    logic             w_load_skid;
    logic             w_skid_to_main;

    flags_t           w_in_flags;
    logic             w_in_xfer;
    logic             w_out_xfer;

    // ------------------------------------------------------------------
    // Flags are computed once on the input path and travel with the data
    // ------------------------------------------------------------------
    alu_flag_gen #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_flag_gen (
        .result_i (in_result),
        .sel_i    (in_sel),
        .flags_o  (w_in_flags)
    );

    // Handshake outputs are direct state-flop bits (no path from out_ready)
    assign out_valid  = state_q[0];
    assign in_ready   = ~state_q[1];

    assign w_in_xfer  = in_valid  & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Occupancy FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy FSM: next state and data-movement strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        w_load_main_in = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    state_d        = ST_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                case ({w_in_xfer, w_out_xfer})
                    2'b10: begin
                        // Consumer stalled: park the new result in the skid
                        state_d     = ST_FULL;
                        w_load_skid = 1'b1;
                    end
                    2'b01: begin
                        state_d = ST_EMPTY;
                    end
                    2'b11: begin
                        // Pass-through: main drains and refills in one edge
                        state_d        = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                    default: begin
                        state_d = ST_ONE;
                    end
                endcase
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can occur
                if (w_out_xfer) begin
                    state_d        = ST_ONE;
                    w_skid_to_main = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Main register (drives out_*)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_result_q <= '0;
            main_sel_q    <= '0;
            main_flags_q  <= '0;
        end else if (w_load_main_in) begin
            main_result_q <= in_result;
            main_sel_q    <= in_sel;
            main_flags_q  <= w_in_flags;
        end else if (w_skid_to_main) begin
            main_result_q <= skid_result_q;
            main_sel_q    <= skid_sel_q;
            main_flags_q  <= skid_flags_q;
        end
    end

    // ------------------------------------------------------------------
    // Skid register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_result_q <= '0;
            skid_sel_q    <= '0;
            skid_flags_q  <= '0;
        end else if (w_load_skid) begin
            skid_result_q <= in_result;
            skid_sel_q    <= in_sel;
            skid_flags_q  <= w_in_flags;
        end
    end

    // ------------------------------------------------------------------
    // Delivered-result counter, sticks at all-ones
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (w_out_xfer && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_result   = main_result_q;
    assign out_sel      = main_sel_q;
    assign out_zero     = main_flags_q.zero;
    assign out_neg      = main_flags_q.neg;
    assign out_parity   = main_flags_q.parity;
    assign out_illegal  = main_flags_q.illegal;
    assign result_count = count_q;

endmodule : alu_result_stage
`default_nettype wire

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU operation-select mux that chooses between XOR_32 and the other 32-bit op units.
- Captures the selected 32-bit result and its select code behind a valid/ready handshake, with a 2-entry skid buffer.
- Attaches status flags (zero, negative, parity, illegal-select).
- Keeps a saturating count of results delivered to the consumer (writeback / register file).

Parameters:
- WIDTH, 32, datapath width of result
- SEL_W, 3, width of op-select code
- CNT_W, 16, width of delivered-result counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream mux output valid
- in_ready  output  1  stage can accept a result this cycle
- in_result  input  WIDTH  selected op-unit result
- in_sel  input  SEL_W  op-select code that produced in_result
- out_valid  output  1  out_* holds a valid result
- out_ready  input  1  consumer accepts the result
- out_result  output  WIDTH  registered result
- out_sel  output  SEL_W  registered select code
- out_zero  output  1  out_result == 0
- out_neg  output  1  out_result[WIDTH-1]
- out_parity  output  1  XOR-reduction of out_result (1 = odd number of ones)
- out_illegal  output  1  out_sel > SEL_MAX (4)
- result_count  output  CNT_W  number of output transfers since reset, saturating

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high. On reset assertion, immediately:
  - out_valid=0, out_result=0, out_sel=0, all flags=0, result_count=0
  - skid entry emptied
  - in_ready=1 from the first cycle after reset
- Transfers: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Storage: main register (drives out_*) plus one skid register. in_ready = !skid_valid (combinational from state only; no path from out_ready).
- Flags: computed from the incoming data when it is written into either register and stored alongside it. Outputs are pure register outputs.
- Latency: 1 cycle. Data accepted at edge N appears on out_* after edge N when the main register was empty or being drained.
- States (occupancy): EMPTY (main and skid invalid), ONE (main valid), FULL (main and skid valid).
  - EMPTY + in xfer -> ONE, data to main.
  - ONE + in xfer, no out xfer -> FULL, data to skid.
  - ONE + out xfer, no in xfer -> EMPTY.
  - ONE + in xfer + out xfer -> ONE, new data to main (pass-through).
  - FULL + out xfer -> ONE, skid moves to main. in_ready=0 in FULL, so no simultaneous in xfer.
- Ordering: strict FIFO; no result dropped or duplicated.
- out_* hold stable while out_valid=1 and out_ready=0.
- in_valid=1 with in_ready=0: upstream holds its data; the stage ignores it.
- result_count increments by 1 per output transfer and saturates at 2^CNT_W-1 (no wrap).
- Illegal select (5..7): the data is passed through unchanged with out_illegal=1; it is not dropped.
- Reset mid-operation discards both entries; no partial transfer completes.

Decomposition:
- Shared package alu_pkg:
  - select codes SEL_ADD=0, SEL_SUB=1, SEL_XOR=2, SEL_SLT=3, SEL_AND=4
  - SEL_MAX=4
  - default WIDTH=32
- One natural sub-module: alu_flag_gen (combinational; result -> zero, neg, parity; sel -> illegal), instantiated once on the input path.

Test Plan:
- Reset: assert reset mid-stream with both entries full -> out_valid=0, in_ready=1, result_count=0 immediately, without waiting for a clock edge.
- Single XOR result, out_ready=1:
  - in_result=0xFFFFFFFF (0x55555555^0xAAAAAAAA), in_sel=2 -> next cycle out_result=0xFFFFFFFF, neg=1, zero=0, parity=0, illegal=0, count=1.
- Zero result:
  - in_result=0x00000000 (0x55555555^0x55555555), in_sel=2 -> out_zero=1, out_neg=0, out_parity=0.
- Backpressure:
  - out_ready=0; send 0x00000001 then 0x80000000 -> in_ready=0 after the second; out_* hold 0x00000001 (parity=1).
  - Raise out_ready -> 0x00000001 then 0x80000000 (neg=1) delivered in order; count=2.
- Streaming: in_valid=1 and out_ready=1 for 100 cycles with an incrementing result -> one transfer per cycle, values in order, in_ready never drops.
- Illegal select and saturation:
  - in_sel=7 -> out_illegal=1 with data intact.
  - With CNT_W=4, deliver 20 results -> result_count sticks at 15.
